uart_receive: RTL and testbench

//   8N1 UART receiver. Deserialises the rx line into bytes, one idle-high frame
//   of {start=0, data[7:0] LSB first, stop=1}. Sits at the host-link input and
//   is the counterpart of the UART transmitter on the same link.

---
 rtl/uart_receive_if.sv | 24 ++
 rtl/uart_receive.sv | 127 ++++++++++++
 tb/tb_uart_receive.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_receive_if.sv
// Receive-side link bundle: serial line in, byte and status strobes out.
interface uart_receive_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output data_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronises rx, detects the start edge, samples each
// bit at its midpoint and emits one-cycle data_valid / frame_err strobes.
module uart_receive #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 460800
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_receive_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, next_state;
  logic        rx_meta, rx_s, rx_prev;
  logic [13:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift_reg;

  logic fall_edge, half_hit, bit_hit;
  logic cnt_clear, cnt_inc, idx_clear, shift_en, load_data, flag_err;

  assign fall_edge = rx_prev & ~rx_s;
  assign half_hit  = (clk_count == HALF_LAST);
  assign bit_hit   = (clk_count == BIT_LAST);

  // Two-flop synchroniser plus one-cycle delay for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a line held low never produces a falling edge, so a break cannot start a frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (fall_edge) next_state = START;
      START: if (half_hit)  next_state = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && bit_index == 3'd7) next_state = STOP;
      STOP:  if (bit_hit)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: busy and the datapath strobes for counters, shifter and result registers.
  always_comb begin
    bus.busy  = (state != IDLE);
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    idx_clear = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    flag_err  = 1'b0;
    case (state)
      IDLE: cnt_clear = fall_edge;
      START: begin
        if (half_hit) begin
          cnt_clear = 1'b1;
          idx_clear = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (bit_hit) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (bit_hit) begin
          load_data = rx_s;
          flag_err  = ~rx_s;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit timing counters, output byte and the one-cycle result strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_count      <= '0;
      bit_index      <= '0;
      bus.data       <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.data_valid <= load_data;
      bus.frame_err  <= flag_err;
      if (cnt_clear)    clk_count <= '0;
      else if (cnt_inc) clk_count <= clk_count + 14'd1;
      if (idx_clear)     bit_index <= '0;
      else if (shift_en) bit_index <= bit_index + 3'd1;
      if (load_data) bus.data <= shift_reg;
    end
  end

  // LSB-first deserialiser: samples enter at the MSB so the first bit ends in bit 0.
  always_ff @(posedge clk) begin
    if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: directed scenarios plus randomized frames, checked
// against a frame-level model (queue of expected bytes and frame-error count).
module tb_uart_receive;

  localparam int CPB  = 217;
  localparam int HB   = 108;
  localparam int NOM  = 9 * CPB + HB + 3;
  localparam int FAST = 213;   // BAUD*1.02
  localparam int SLOW = 221;   // BAUD*0.98

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_receive_if bus();

  uart_receive #(.CLK_FREQ(100_000_000), .BAUD(460800)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int exp_ferr = 0;
  int obs_ferr = 0;
  bit lat_chk = 1'b0;
  logic prev_dv = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe strobes away from the active edge and log received bytes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_valid) begin
        obs_q.push_back(bus.data);
        check("dv_single_clk", 32'(prev_dv), 32'd0);
        check("dv_busy_low", 32'(bus.busy), 32'd0);
        check("dv_fe_exclusive", 32'(bus.frame_err), 32'd0);
        if (lat_chk) begin
          int lat;
          lat = cyc - (start_cyc + 1);
          check("latency_window", 32'(lat >= NOM - 2 && lat <= NOM + 2), 32'd1);
          lat_chk = 1'b0;
        end
      end
      if (bus.frame_err) begin
        obs_ferr++;
        check("fe_data_hold", 32'(bus.data), 32'(last_good));
        check("fe_busy_low", 32'(bus.busy), 32'd0);
      end
    end
    prev_dv = bus.data_valid;
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb);
    bus.rx = 1'b0;
    start_cyc = cyc;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    bus.rx = stop;
    repeat (cpb) @(negedge clk);
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic end_phase(input string tag);
    int n;
    idle(2 * CPB);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_ferr"}, 32'(obs_ferr), 32'(exp_ferr));
    check({tag, "_data_reg"}, 32'(bus.data), 32'(last_good));
    obs_q.delete();
    exp_q.delete();
    obs_ferr = 0;
    exp_ferr = 0;
  endtask

  initial begin
    logic [7:0] b;
    logic good;
    int cpb;
    int gap;

    // Reset with idle line: every output at its reset value.
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_dv", 32'(bus.data_valid), 32'd0);
    check("rst_fe", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single byte at nominal rate, with latency window.
    lat_chk = 1'b1;
    send_frame(8'hA5, 1'b1, CPB);
    end_phase("t1");
    check("t1_latency_seen", 32'(lat_chk), 32'd0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    end_phase("t2");

    // Short low glitch: busy rises then falls, no strobes.
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_glitch_busy_hi", 32'(bus.busy), 32'd1);
    repeat (40) @(negedge clk);
    idle(HB + 10);
    check("t3_glitch_busy_lo", 32'(bus.busy), 32'd0);
    send_frame(8'h3C, 1'b1, CPB);
    end_phase("t3");

    // Bad stop bit followed by a long break, then a good byte.
    send_frame(8'h3C, 1'b0, CPB);
    repeat (5 * CPB) @(negedge clk);
    check("t4_break_busy_lo", 32'(bus.busy), 32'd0);
    repeat (15 * CPB) @(negedge clk);
    idle(2 * CPB);
    send_frame(8'h55, 1'b1, CPB);
    end_phase("t4");

    // Reset during bit 4 of 0x96 aborts the frame.
    b = 8'h96;
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_data", 32'(bus.data), 32'd0);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle(3 * CPB);
    send_frame(8'h69, 1'b1, CPB);
    end_phase("t5");

    // Baud error tolerance, fast and slow transmitter.
    send_frame(8'h5A, 1'b1, FAST);
    idle(CPB);
    send_frame(8'h5A, 1'b1, SLOW);
    end_phase("t6");

    // Randomized frames: random bytes, rates, gaps and stop-bit faults.
    for (int k = 0; k < 10; k++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 2))
        0:       cpb = FAST;
        1:       cpb = CPB;
        default: cpb = SLOW;
      endcase
      gap = $urandom_range(0, 2);
      if (!good && gap == 0) gap = 1;
      send_frame(b, good, cpb);
      if (gap > 0) idle(gap * cpb);
    end
    end_phase("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
